lsu: RTL and testbench
======================

# lsu

Load/store unit forming the MEM stage of the RISC-V pipeline. It takes the address (ALU result), store data and control from the EX/MEM pipeline register, issues one request at a time to the data memory bus over a valid/ready request channel and a valid response channel, aligns store bytes, and sign- or zero-extends load data. It holds the pipeline stalled until each access finishes.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  EX/MEM: instruction is a load
- mem_write  in  1  EX/MEM: instruction is a store (never both with mem_read)
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (ALU result)
- store_data  in  32  forwarded rs2 value
- dmem_req_valid  out  1  bus request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_we  out  1  1 = write
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_rsp_valid  in  1  read data valid (loads only)
- dmem_rsp_rdata  in  32  read word
- lsu_stall  out  1  hold IF/ID/EX and EX/MEM registers
- load_data  out  32  extended load result, valid in DONE
- lsu_done  out  1  access complete this cycle (one-cycle pulse)
- lsu_err  out  1  misaligned or illegal funct3, one-cycle pulse with lsu_done

## Operation
- States: IDLE, REQ, WAIT, DONE.
- op = mem_read | mem_write.
- IDLE, op, legal and aligned: latch dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, funct3 and addr[1:0]; go to REQ.
- IDLE, op, illegal: go to DONE with the error flag set; no bus request is issued.
- Illegal means any of:
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - funct3 in {011,110,111};
  - store funct3 outside {000,001,010}.
- REQ: dmem_req_valid=1, outputs held stable until handshake.
  - REQ & dmem_req_ready & we: go to DONE.
  - REQ & dmem_req_ready & ~we: go to WAIT.
- WAIT & dmem_rsp_valid: capture the extended rdata into the load_data register; go to DONE.
  - rsp_valid in any other state is ignored.
- DONE: lsu_done=1, lsu_err=error flag; go to IDLE unconditionally.
- lsu_stall = (op & state≠DONE). It is combinational, so it asserts in the same cycle op appears. The pipeline advances on the DONE cycle.
- Store lanes:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = store_data.
  - Loads: wstrb = 0.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]).
  - Half = rdata >> (16*addr[1]).
  - B/H sign-extend from bit 7/15; BU/HU zero-extend.
- load_data holds its value until the next load completes.

## Timing
- Reset values (async on rst_n=0): state IDLE, dmem_req_valid 0, dmem_addr 0, dmem_we 0, dmem_wstrb 0, dmem_wdata 0, load_data 0, lsu_done 0, lsu_err 0.
  - lsu_stall follows its equation (op & state≠DONE).
- Reset mid-operation aborts the access. A response arriving after reset is ignored.
- Store, ready=1 (op at cycle N): REQ N+1, DONE N+2. Stall is high in N and N+1.
- Load, ready=1, response one cycle after handshake: REQ N+1, WAIT N+2, DONE N+3. Three stall cycles.
- Response in the same cycle as the handshake is not possible: at least one WAIT cycle.
- Misaligned access: DONE at N+1, one stall cycle, no dmem_req_valid.
- dmem_req_valid never drops before ready. Request fields never change while valid & ~ready.
- Back-to-back ops: the next op is seen in IDLE the cycle after DONE. There is no bubble beyond the state sequence.

## Test plan
- SB, addr=0x1003, store_data=0xA5: REQ shows dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, we=1. Stall for 2 cycles; lsu_done at N+2.
- LH, addr=0x2002, rdata=0x8001_7FFF: load_data=0xFFFF8001. Same stimulus with LHU: load_data=0x00008001.
- LW, addr=0x300, dmem_req_ready low 3 cycles then high, rsp 2 cycles later: req_valid stays high with fields stable, load_data=rdata, and stall holds throughout.
- SW, addr=0x102: no request, lsu_err=1 and lsu_done=1 at N+1, one stall cycle.
- rst_n pulsed low while in WAIT, then rsp_valid=1: state IDLE, load_data=0, no lsu_done.
- LB, addr=0x01 (rdata=0x0000_8000), then SW, addr=0x04 the next cycle after DONE: load_data=0xFFFFFF80, then the store issues with no extra bubble.

Source files
------------

// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit for the MEM stage of the RISC-V pipeline.
//             Issues one data-bus access at a time over a valid/ready request
//             channel and a valid-only response channel. It places store bytes
//             on the correct lanes and sign- or zero-extends load data. The
//             pipeline is held stalled until the access completes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   pipeline clock
//    rst_n           in   1   asynchronous active-low reset
//    mem_read        in   1   EX/MEM: instruction is a load
//    mem_write       in   1   EX/MEM: instruction is a store
//    funct3          in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//    addr            in  32   byte address (ALU result)
//    store_data      in  32   forwarded rs2 value
//    dmem_req_valid  out  1   bus request valid
//    dmem_req_ready  in   1   bus accepts request
//    dmem_addr       out 32   word-aligned bus address
//    dmem_we         out  1   1 = write
//    dmem_wstrb      out  4   byte enables
//    dmem_wdata      out 32   lane-replicated write data
//    dmem_rsp_valid  in   1   read data valid (loads only)
//    dmem_rsp_rdata  in  32   read word
//    lsu_stall       out  1   hold IF/ID/EX and EX/MEM registers
//    load_data       out 32   extended load result
//    lsu_done        out  1   access complete this cycle (pulse)
//    lsu_err         out  1   misaligned / illegal access (pulse with done)
// ============================================================================
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        lsu_done,
  output logic        lsu_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  state_t      r_state;
  logic [2:0]  r_funct3;   // access type of the load in flight
  logic [1:0]  r_addr_lo;  // byte offset of the load in flight

  logic        w_op;
  logic        w_legal;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_rsp_byte;
  logic [15:0] w_rsp_half;
  logic [31:0] w_load_ext;

  assign w_op = mem_read | mem_write;

  // Stall is combinational so the pipeline freezes in the very cycle the
  // access appears; it releases on DONE, where the pipeline advances.
  assign lsu_stall = w_op & (r_state != S_DONE);

  // Legality: size must be defined, address naturally aligned, and the
  // unsigned variants only exist for loads.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      c_F3_B:  w_legal = 1'b1;
      c_F3_H:  w_legal = ~addr[0];
      c_F3_W:  w_legal = (addr[1:0] == 2'b00);
      c_F3_BU: w_legal = mem_read;
      c_F3_HU: w_legal = mem_read & ~addr[0];
      default: w_legal = 1'b0;
    endcase
  end

  // Store lanes: data is replicated across the word so the byte enables alone
  // select the target lane(s). Loads never enable a write lane.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
      end
    endcase
    if (!mem_write) begin
      w_wstrb = 4'b0000;
    end
  end

  // Load extraction uses the offset latched at request time, since the
  // address inputs may already be stale while waiting for the response.
  always_comb begin
    w_rsp_byte = dmem_rsp_rdata[7:0];
    case (r_addr_lo)
      2'd0:    w_rsp_byte = dmem_rsp_rdata[7:0];
      2'd1:    w_rsp_byte = dmem_rsp_rdata[15:8];
      2'd2:    w_rsp_byte = dmem_rsp_rdata[23:16];
      default: w_rsp_byte = dmem_rsp_rdata[31:24];
    endcase
    w_rsp_half = r_addr_lo[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];
  end

  always_comb begin
    w_load_ext = dmem_rsp_rdata;
    case (r_funct3)
      c_F3_B:  w_load_ext = {{24{w_rsp_byte[7]}}, w_rsp_byte};
      c_F3_H:  w_load_ext = {{16{w_rsp_half[15]}}, w_rsp_half};
      c_F3_BU: w_load_ext = {24'h000000, w_rsp_byte};
      c_F3_HU: w_load_ext = {16'h0000, w_rsp_half};
      default: w_load_ext = dmem_rsp_rdata;
    endcase
  end

  // Control FSM. Bus fields are captured once in IDLE and held untouched
  // until the next access, which keeps them stable across a ready stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_funct3       <= 3'b000;
      r_addr_lo      <= 2'b00;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= 32'h0000_0000;
      dmem_we        <= 1'b0;
      dmem_wstrb     <= 4'b0000;
      dmem_wdata     <= 32'h0000_0000;
      load_data      <= 32'h0000_0000;
      lsu_done       <= 1'b0;
      lsu_err        <= 1'b0;
    end else begin
      lsu_done <= 1'b0;
      lsu_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            if (w_legal) begin
              dmem_addr      <= {addr[31:2], 2'b00};
              dmem_we        <= mem_write;
              dmem_wstrb     <= w_wstrb;
              dmem_wdata     <= w_wdata;
              r_funct3       <= funct3;
              r_addr_lo      <= addr[1:0];
              dmem_req_valid <= 1'b1;
              r_state        <= S_REQ;
            end else begin
              // Faulting access: report straight away, bus untouched.
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (dmem_we) begin
              lsu_done <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rsp_valid) begin
            load_data <= w_load_ext;
            lsu_done  <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu. Acts as pipeline and data memory,
//             drives scripted and randomized accesses, and compares the DUT
//             every cycle against a timeline-based transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        lsu_stall;
  logic [31:0] load_data;
  logic        lsu_done;
  logic        lsu_err;

  lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .lsu_stall      (lsu_stall),
    .load_data      (load_data),
    .lsu_done       (lsu_done),
    .lsu_err        (lsu_err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected outputs for the current cycle, set just after each rising edge.
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_req, exp_done, exp_err, exp_we, exp_chk_wdata;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] model_last_load = 32'h0;

  // Observations used by the directed literal checks.
  int          stall_cnt, done_cnt, req_seen;
  bit          cap_err;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  bit          cap_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (!ld && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (int'(a[1:0]) % nbytes) == 0;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    int m;
    nbytes = 1 << f3[1:0];
    m = ((1 << nbytes) - 1) << a[1:0];
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'd0:    return 32'(sd[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(sd[15:0]) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    int nbits;
    logic [31:0] v, mask;
    nbits = 8 * (1 << f3[1:0]);
    v = rd >> (8 * int'(lo));
    if (nbits >= 32) return v;
    mask = (32'h1 << nbits) - 32'h1;
    v = v & mask;
    if (!f3[2] && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
      check("dmem_req_valid", 32'(dmem_req_valid), 32'(exp_req));
      check("lsu_done", 32'(lsu_done), 32'(exp_done));
      check("lsu_err", 32'(lsu_err), 32'(exp_err));
      check("load_data", load_data, model_last_load);
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
        if (exp_chk_wdata) check("dmem_wdata", dmem_wdata, exp_wdata);
        cap_addr  = dmem_addr;
        cap_wdata = dmem_wdata;
        cap_wstrb = dmem_wstrb;
        cap_we    = dmem_we;
      end
      if (lsu_stall) stall_cnt++;
      if (dmem_req_valid) req_seen++;
      if (lsu_done) begin
        done_cnt++;
        cap_err = lsu_err;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_we = 1'b0; exp_chk_wdata = 1'b0;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; done_cnt = 0; req_seen = 0; cap_err = 1'b0;
  endtask

  task automatic noise();
    dmem_req_ready = 1'($urandom_range(0, 1));
    dmem_rsp_valid = 1'($urandom_range(0, 1));
    dmem_rsp_rdata = $urandom;
  endtask

  task automatic set_req_exp(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    exp_req       = 1'b1;
    exp_addr      = {a[31:2], 2'b00};
    exp_we        = ~ld;
    exp_wstrb     = ld ? 4'h0 : model_wstrb(f3, a);
    exp_chk_wdata = ~ld;
    exp_wdata     = model_wdata(f3, sd);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'($urandom_range(0, 7)); addr = $urandom; store_data = $urandom;
    noise(); clear_exp();
  endtask

  // One access: dr = cycles ready stays low in REQ, dw = cycles from handshake
  // to response (>=1). Returns just after the edge that starts the DONE cycle.
  task automatic do_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int dr, input int dw, input logic [31:0] rd);
    bit legal;
    legal = model_legal(ld, f3, a);
    @(posedge clk); #1;
    mem_read = ld; mem_write = ~ld; funct3 = f3; addr = a; store_data = sd;
    noise(); clear_exp(); exp_stall = 1'b1;
    if (!legal) begin
      @(posedge clk); #1;
      noise(); clear_exp(); exp_done = 1'b1; exp_err = 1'b1;
    end else begin
      for (int i = 0; i <= dr; i++) begin
        @(posedge clk); #1;
        noise();
        dmem_req_ready = (i == dr);
        if (i == dr) dmem_rsp_valid = 1'b0;
        clear_exp(); exp_stall = 1'b1; set_req_exp(ld, f3, a, sd);
      end
      if (ld) begin
        for (int i = 1; i <= dw; i++) begin
          @(posedge clk); #1;
          noise();
          dmem_rsp_valid = (i == dw);
          if (i == dw) dmem_rsp_rdata = rd;
          clear_exp(); exp_stall = 1'b1;
        end
      end
      @(posedge clk); #1;
      noise(); clear_exp(); exp_done = 1'b1;
      if (ld) model_last_load = model_load(f3, a[1:0], rd);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] ld_f3 [5];
    bit          r_ld;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [1:0]  lo;
    int          gap;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'h0; store_data = 32'h0; dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
    clear_exp(); clr_cnt();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset dmem_req_valid", 32'(dmem_req_valid), 32'h0);
    check("reset dmem_addr", dmem_addr, 32'h0);
    check("reset dmem_we", 32'(dmem_we), 32'h0);
    check("reset dmem_wstrb", 32'(dmem_wstrb), 32'h0);
    check("reset dmem_wdata", dmem_wdata, 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset lsu_done", 32'(lsu_done), 32'h0);
    check("reset lsu_err", 32'(lsu_err), 32'h0);
    check("reset lsu_stall", 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1; clear_exp();

    // SB to the top byte lane
    idle_cycle(); clr_cnt();
    do_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0);
    @(negedge clk); #1;
    check("SB addr", cap_addr, 32'h0000_1000);
    check("SB wstrb", 32'(cap_wstrb), 32'h8);
    check("SB wdata", cap_wdata, 32'hA5A5_A5A5);
    check("SB we", 32'(cap_we), 32'h1);
    check("SB stall cycles", 32'(stall_cnt), 32'd2);
    check("SB done count", 32'(done_cnt), 32'd1);

    // LH / LHU on the upper half
    idle_cycle(); clr_cnt();
    do_txn(1'b1, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_7FFF);
    @(negedge clk); #1;
    check("LH load_data", load_data, 32'hFFFF_8001);
    check("LH stall cycles", 32'(stall_cnt), 32'd3);
    idle_cycle();
    do_txn(1'b1, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_7FFF);
    @(negedge clk); #1;
    check("LHU load_data", load_data, 32'h0000_8001);

    // LW with ready held low 3 cycles and response 2 cycles after handshake
    idle_cycle(); clr_cnt();
    do_txn(1'b1, 3'b010, 32'h0000_0300, 32'h0, 3, 2, 32'h1234_5678);
    @(negedge clk); #1;
    check("LW load_data", load_data, 32'h1234_5678);
    check("LW stall cycles", 32'(stall_cnt), 32'd7);
    check("LW req_valid cycles", 32'(req_seen), 32'd4);

    // Misaligned SW
    idle_cycle(); clr_cnt();
    do_txn(1'b0, 3'b010, 32'h0000_0102, 32'hCAFE_F00D, 0, 1, 32'h0);
    @(negedge clk); #1;
    check("SW misaligned err", 32'(cap_err), 32'h1);
    check("SW misaligned done", 32'(done_cnt), 32'd1);
    check("SW misaligned no req", 32'(req_seen), 32'd0);
    check("SW misaligned stall", 32'(stall_cnt), 32'd1);

    // LB then SW back to back
    idle_cycle(); clr_cnt();
    do_txn(1'b1, 3'b000, 32'h0000_0001, 32'h0, 0, 1, 32'h0000_8000);
    @(negedge clk); #1;
    check("LB load_data", load_data, 32'hFFFF_FF80);
    clr_cnt();
    do_txn(1'b0, 3'b010, 32'h0000_0004, 32'h1357_9BDF, 0, 1, 32'h0);
    @(negedge clk); #1;
    check("b2b SW stall cycles", 32'(stall_cnt), 32'd2);
    check("b2b SW wstrb", 32'(cap_wstrb), 32'hF);
    check("b2b SW addr", cap_addr, 32'h0000_0004);

    // Reset during WAIT, then a late response
    idle_cycle(); clr_cnt();
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    clear_exp(); exp_stall = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    clear_exp(); exp_stall = 1'b1; set_req_exp(1'b1, 3'b010, 32'h0000_0300, store_data);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    clear_exp(); exp_stall = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0; model_last_load = 32'h0; clear_exp();
    #1;
    check("async reset req_valid", 32'(dmem_req_valid), 32'h0);
    check("async reset load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("post-reset no done", 32'(done_cnt), 32'd0);
    check("post-reset load_data", load_data, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      r_ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_ld) r_f3 = ld_f3[$urandom_range(0, 4)];
      else r_f3 = 3'($urandom_range(0, 2));
      r_a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        lo = 2'($urandom_range(0, 3));
        if (r_f3[1:0] == 2'd1) lo[0] = 1'b0;
        if (r_f3[1:0] == 2'd2) lo = 2'd0;
        r_a[1:0] = lo;
      end
      do_txn(r_ld, r_f3, r_a, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), $urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
`default_nettype wire
